siso_shift_ctrl: RTL and testbench
==================================

Name: siso_shift_ctrl

Overview:
Sequencing controller for a DEPTH-stage serial-in/serial-out shift register chain. It accepts a parallel word over a valid/ready handshake and drives it bit-serially into the chain with a shift enable. It then flushes the chain and reassembles the bits emerging at the chain output into a parallel result word, presented over a second handshake. It sits between a parallel producer/consumer and the SISO datapath, and also serves as a loopback checker for the chain.

Parameters:
WIDTH, 8, word length in bits (>=2)
DEPTH, 4, number of flop stages in the attached SISO chain (>=1)
MSB_FIRST, 1, 1 = shift MSB first, 0 = LSB first; the same order is used for reassembly

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
tx_data  in  WIDTH  word to serialize
tx_valid  in  1  tx_data valid
tx_ready  out  1  controller can accept a word
sr_si  out  1  serial data to chain input
sr_en  out  1  shift enable to chain; chain shifts on clk edges where sr_en=1
sr_so  in  1  serial data from chain output
rx_data  out  WIDTH  reassembled word
rx_valid  out  1  rx_data/match valid
rx_ready  in  1  consumer accepts rx_data
match  out  1  rx_data equals the word that was sent
busy  out  1  state != IDLE

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-low. While rst=0: state=IDLE, count=0, and sr_si, sr_en, rx_valid, match, busy are 0; rx_data and the internal tx word register are 0. tx_ready is forced to 0 while rst=0.
- States: IDLE, SHIFT, FLUSH, DONE. count width = clog2(WIDTH+DEPTH+1).
- IDLE:
  - tx_ready=1.
  - On tx_valid&tx_ready: latch tx_data into the shift word and a copy into the reference word. Set count=0 and go to SHIFT.
- SHIFT:
  - sr_en=1. sr_si = current head bit (MSB if MSB_FIRST, else LSB).
  - The shift word advances each cycle.
  - When count=WIDTH-1, go to FLUSH.
- FLUSH:
  - sr_en=1, sr_si=0.
  - When count=WIDTH+DEPTH-1, go to DONE and set rx_valid=1.
- Count and capture:
  - count increments on every enabled edge.
  - On an enabled edge with DEPTH <= count <= WIDTH+DEPTH-1, sample sr_so into the rx shift word, in the same bit order as sent. This gives exactly WIDTH captures.
  - For DEPTH > WIDTH, captures occur only in FLUSH.
- DONE:
  - sr_en=0, sr_si=0, rx_valid=1.
  - match = (rx_data == reference word), registered at DONE entry.
  - rx_data and match are held stable until rx_ready=1. On that edge: rx_valid->0, go to IDLE.
- Latency:
  - rx_valid rises WIDTH+DEPTH cycles after the acceptance edge.
  - Minimum acceptance-to-acceptance period is WIDTH+DEPTH+2 cycles when rx_ready is held 1.
- Boundaries:
  - tx_valid outside IDLE is ignored, with no side effects.
  - In DONE, tx_ready=0. A tx_valid coincident with rx_ready is accepted no earlier than the following cycle.
  - rx_ready outside DONE is ignored.
  - Reset mid-operation: immediate return to the reset values above. The partially shifted word is discarded. Chain contents are not cleared by this block.
  - sr_en is never asserted in IDLE or DONE. The chain is therefore frozen while the result is held.

Decomposition:
- Package siso_shift_ctrl_pkg holds:
  - the state encoding (IDLE=2'd0, SHIFT=2'd1, FLUSH=2'd2, DONE=2'd3);
  - a clog2 constant function for the count width.
- Single module; no sub-module is warranted. The bench provides a behavioural DEPTH-stage SISO model with enable.

Test Plan:
1. WIDTH=8, DEPTH=4, MSB_FIRST=1, tx_data=8'hB5, rx_ready=1 -> sr_si=1,0,1,1,0,1,0,1 then 0,0,0,0 with sr_en=1 for 12 cycles. rx_valid rises 12 cycles after acceptance with rx_data=8'hB5, match=1, then IDLE.
2. Backpressure: same word, rx_ready=0 for 5 cycles after rx_valid -> rx_valid, rx_data=8'hB5 and match are held; sr_en=0; tx_ready=0 even with tx_valid=1. After rx_ready=1: IDLE, and the next word is accepted one cycle later.
3. Reset mid-shift: assert rst=0 at count=5 -> outputs go to 0 asynchronously and tx_ready=0. After release: IDLE, tx_ready=1; the word 8'h3C is then sent and returns 8'h3C, match=1.
4. Faulty chain: bench chain output stuck at 0, tx_data=8'hFF -> rx_data=8'h00, match=0.
5. MSB_FIRST=0, tx_data=8'h01 -> first sr_si bit=1, remaining seven 0; rx_data=8'h01.
6. DEPTH=10 > WIDTH=8, tx_data=8'hA5 -> 18 enabled cycles, captures only during FLUSH, rx_data=8'hA5, match=1.

Source files
------------

// File: rtl/siso_shift_ctrl_pkg.sv
// Shared types and helpers for the SISO chain sequencing controller.
package siso_shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/siso_shift_ctrl.sv
// Serializes a parallel word into a SISO chain, flushes it through, and
// reassembles the chain output into a result word with a loopback match flag.
//
// state | meaning
// IDLE  | ready for a new word, chain frozen
// SHIFT | driving word bits into the chain, head bit first
// FLUSH | driving zeros while the tail of the word drains out
// DONE  | result held for the consumer, chain frozen
module siso_shift_ctrl
  import siso_shift_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             sr_si_o,
  output logic             sr_en_o,
  input  logic             sr_so_i,
  output logic [WIDTH-1:0] rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             match_o,
  output logic             busy_o
);

  localparam int CW = clog2(WIDTH + DEPTH + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_FLUSH = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] FIRST_CAP  = CW'(DEPTH);

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic             sr_si_q, sr_en_q, rx_valid_q, match_q;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // The first DEPTH enabled edges only push the word into the chain;
  // from then on every enabled edge sees a valid bit at the chain output.
  always_comb begin
    shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0} : {1'b0, shift_q[WIDTH-1:1]};
    rx_d    = rx_q;
    if (sr_en_q && (count_q >= FIRST_CAP))
      rx_d = MSB_FIRST ? {rx_q[WIDTH-2:0], sr_so_i} : {sr_so_i, rx_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      shift_q    <= '0;
      ref_q      <= '0;
      rx_q       <= '0;
      sr_si_q    <= 1'b0;
      sr_en_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      match_q    <= 1'b0;
    end else begin
      rx_q <= rx_d;
      if (sr_en_q) count_q <= count_q + CW'(1);
      case (state_q)
        IDLE: begin
          if (tx_valid_i) begin
            shift_q <= tx_data_i;
            ref_q   <= tx_data_i;
            count_q <= '0;
            sr_en_q <= 1'b1;
            sr_si_q <= head_bit(tx_data_i);
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          if (count_q == LAST_SHIFT) begin
            sr_si_q <= 1'b0;
            state_q <= FLUSH;
          end else begin
            sr_si_q <= head_bit(shift_d);
          end
        end
        FLUSH: begin
          if (count_q == LAST_FLUSH) begin
            sr_en_q    <= 1'b0;
            rx_valid_q <= 1'b1;
            match_q    <= (rx_d == ref_q);
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (rx_ready_i) begin
            rx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_ready_o = rst_n && (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign sr_si_o    = sr_si_q;
  assign sr_en_o    = sr_en_q;
  assign rx_data_o  = rx_q;
  assign rx_valid_o = rx_valid_q;
  assign match_o    = match_q;

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Directed bench for siso_shift_ctrl: three configurations, each looped
// through a behavioural enabled SISO chain.
module tb_siso_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       stuck = 1'b0;

  logic       tx_valid [3];
  logic       rx_ready [3];
  logic       tx_ready [3];
  logic       sr_si    [3];
  logic       sr_en    [3];
  logic       sr_so    [3];
  logic [7:0] rx_data  [3];
  logic       rx_valid [3];
  logic       match    [3];
  logic       busy     [3];

  logic [7:0] last_rx [3];
  int         DEP  [3] = '{4, 4, 10};
  bit         MSBF [3] = '{1'b1, 1'b0, 1'b1};

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  siso_shift_ctrl #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid[0]),
    .tx_ready_o(tx_ready[0]), .sr_si_o(sr_si[0]), .sr_en_o(sr_en[0]), .sr_so_i(sr_so[0]),
    .rx_data_o(rx_data[0]), .rx_valid_o(rx_valid[0]), .rx_ready_i(rx_ready[0]),
    .match_o(match[0]), .busy_o(busy[0]));

  siso_shift_ctrl #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid[1]),
    .tx_ready_o(tx_ready[1]), .sr_si_o(sr_si[1]), .sr_en_o(sr_en[1]), .sr_so_i(sr_so[1]),
    .rx_data_o(rx_data[1]), .rx_valid_o(rx_valid[1]), .rx_ready_i(rx_ready[1]),
    .match_o(match[1]), .busy_o(busy[1]));

  siso_shift_ctrl #(.WIDTH(8), .DEPTH(10), .MSB_FIRST(1'b1)) u_deep (
    .clk(clk), .rst_n(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid[2]),
    .tx_ready_o(tx_ready[2]), .sr_si_o(sr_si[2]), .sr_en_o(sr_en[2]), .sr_so_i(sr_so[2]),
    .rx_data_o(rx_data[2]), .rx_valid_o(rx_valid[2]), .rx_ready_i(rx_ready[2]),
    .match_o(match[2]), .busy_o(busy[2]));

  // Chains are never reset by the controller, so they keep stale bits.
  logic [3:0] ch0 = '0;
  logic [3:0] ch1 = '0;
  logic [9:0] ch2 = '0;

  always @(posedge clk) begin
    if (sr_en[0]) ch0 <= {ch0[2:0], sr_si[0]};
    if (sr_en[1]) ch1 <= {ch1[2:0], sr_si[1]};
    if (sr_en[2]) ch2 <= {ch2[8:0], sr_si[2]};
  end

  assign sr_so[0] = stuck ? 1'b0 : ch0[3];
  assign sr_so[1] = ch1[3];
  assign sr_so[2] = ch2[9];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Entered and left at a falling edge. With hold>0 tx_valid is left high on
  // return so the next word is offered right at the first IDLE cycle.
  task automatic run_word(input int id, input logic [7:0] w, input logic [7:0] exp_rx,
                          input logic exp_m, input int hold);
    int d;
    d = DEP[id];
    tx_data      = w;
    tx_valid[id] = 1'b1;
    rx_ready[id] = (hold == 0);
    check_eq("tx_ready_idle", tx_ready[id], 1);
    check_eq("busy_idle", busy[id], 0);
    @(negedge clk);
    tx_valid[id] = 1'b0;
    for (int k = 0; k < 8 + d; k++) begin
      logic b;
      b = (k < 8) ? (MSBF[id] ? w[7-k] : w[k]) : 1'b0;
      check_eq("en_si", {sr_en[id], sr_si[id]}, {1'b1, b});
      check_eq("no_early_valid", rx_valid[id], 0);
      check_eq("tx_ready_busy", tx_ready[id], 0);
      if (k <= d) check_eq("no_early_capture", rx_data[id], last_rx[id]);
      @(negedge clk);
    end
    check_eq("rx_valid", rx_valid[id], 1);
    check_eq("rx_data", rx_data[id], exp_rx);
    check_eq("match", match[id], exp_m);
    check_eq("done_en", sr_en[id], 0);
    check_eq("done_tx_ready", tx_ready[id], 0);
    for (int h = 0; h < hold; h++) begin
      tx_valid[id] = 1'b1;
      tx_data      = 8'h5A;
      @(negedge clk);
      check_eq("hold_valid", rx_valid[id], 1);
      check_eq("hold_data", rx_data[id], exp_rx);
      check_eq("hold_match", match[id], exp_m);
      check_eq("hold_en_si", {sr_en[id], sr_si[id]}, 0);
      check_eq("hold_tx_ready", tx_ready[id], 0);
      check_eq("hold_busy", busy[id], 1);
    end
    rx_ready[id] = 1'b1;
    @(negedge clk);
    check_eq("ret_busy", busy[id], 0);
    check_eq("ret_valid", rx_valid[id], 0);
    check_eq("ret_tx_ready", tx_ready[id], 1);
    last_rx[id] = exp_rx;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      tx_valid[i] = 1'b0;
      rx_ready[i] = 1'b0;
      last_rx[i]  = 8'h00;
    end
    repeat (2) @(negedge clk);
    check_eq("rst_tx_ready", tx_ready[0], 0);
    check_eq("rst_outs", {sr_si[0], sr_en[0], rx_valid[0], match[0], busy[0]}, 0);
    check_eq("rst_rx_data", rx_data[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_word(0, 8'hB5, 8'hB5, 1'b1, 0);
    run_word(0, 8'hB5, 8'hB5, 1'b1, 5);
    run_word(0, 8'h96, 8'h96, 1'b1, 0);

    // Abort at count=5 while a 1 is on sr_si.
    tx_data     = 8'hE7;
    tx_valid[0] = 1'b1;
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("pre_rst_en_si", {sr_en[0], sr_si[0], busy[0]}, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_outs", {sr_si[0], sr_en[0], rx_valid[0], match[0], busy[0]}, 0);
    check_eq("arst_tx_ready", tx_ready[0], 0);
    check_eq("arst_rx_data", rx_data[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) last_rx[i] = 8'h00;
    @(negedge clk);
    check_eq("post_rst_tx_ready", tx_ready[0], 1);
    check_eq("post_rst_busy", busy[0], 0);
    run_word(0, 8'h3C, 8'h3C, 1'b1, 0);

    stuck = 1'b1;
    run_word(0, 8'hFF, 8'h00, 1'b0, 0);
    stuck = 1'b0;

    run_word(1, 8'h01, 8'h01, 1'b1, 0);
    run_word(2, 8'hA5, 8'hA5, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
